hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be:
- CLK  in  1  clock, all state updates on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt.
- ID_BranchTaken  in  1  branch or jump resolved taken in ID.
- ID_Eret  in  1  ERET in ID.
- ID_PCplus4  in  32  PC+4 of the ID instruction; 0 marks a bubble.
- EX_rs, EX_rt  in  5 each  source registers of the instruction in EX.
- EX_MemRd  in  1  the EX instruction is a load.
- EX_rdes  in  5  destination register in EX.
- MEM_RegWr, MEM_rdes  in  1/5  write enable and destination in MEM.
- WB_RegWr, WB_rdes  in  1/5  write enable and destination in WB.
- IRQ  in  1  asynchronous level interrupt request.
- PC_Hold, IFID_Hold  out  1 each  freeze the PC and the IF/ID register.
- IF_Flush, ID_Flush  out  1 each  clear IF/ID and ID/EX at the next edge.
- IF_Protect  out  1  suppress IF_Flush so the handler's first fetch survives.
- PCSrc_Irq  out  1  select the interrupt vector for the next PC.
- IRQ_Ack  out  1  one-cycle interrupt-accept pulse.
- ForwardA, ForwardB  out  2 each  EX operand source: 00 register file, 10 MEM, 01 WB.
- EPC  out  32  exception return PC.

Function
REQ-003 The controller SHALL be a 3-state FSM: RUN, LDSTALL, IRQENTRY. All outputs except EPC SHALL be combinational from the state, the registers and the inputs.
REQ-004 A load-use hazard (LU) SHALL be true when all of these hold:
- EX_MemRd=1
- EX_rdes!=0
- EX_rdes==ID_rs, or (ID_UsesRt=1 and EX_rdes==ID_rt)
REQ-005 In RUN with LU=1:
- PC_Hold, IFID_Hold and ID_Flush SHALL be 1.
- IF_Flush SHALL be 0, even when ID_BranchTaken=1; the branch re-resolves next cycle.
- The next state SHALL be LDSTALL.
REQ-006 LDSTALL SHALL last exactly one cycle and then return to RUN. In LDSTALL:
- No hold outputs SHALL be asserted.
- ID_BranchTaken SHALL act as in RUN.
- Interrupts SHALL NOT be accepted.
REQ-007 In RUN or LDSTALL with LU=0 and ID_BranchTaken=1, IF_Flush SHALL be 1.
REQ-008 IRQ SHALL pass through a 2-flop synchronizer to give irq_s; acceptance latency from IRQ rising SHALL be at least 2 cycles.
REQ-009 An interrupt SHALL be accepted in RUN only when all of these hold:
- irq_s=1
- int_en=1
- LU=0
- ID_BranchTaken=0
- ID_Eret=0
- ID_PCplus4!=0
Otherwise it SHALL stay pending while IRQ is held.
REQ-010 In the acceptance cycle:
- IF_Flush, ID_Flush, PCSrc_Irq and IRQ_Ack SHALL be 1.
- At the edge, EPC SHALL load ID_PCplus4-4 (32-bit, wrap-around modulo 2^32) and int_en SHALL clear.
- The next state SHALL be IRQENTRY.
REQ-011 IRQENTRY SHALL last exactly one cycle and then return to RUN. In IRQENTRY:
- IF_Protect SHALL be 1.
- IF_Flush SHALL be 0.
- ID_BranchTaken SHALL be ignored.
- No interrupt SHALL be accepted.
REQ-012 ID_Eret=1 in RUN with LU=0 SHALL set int_en at the next edge. An interrupt SHALL NOT be accepted in that same cycle.
REQ-013 ForwardA SHALL be:
- 10 when MEM_RegWr=1, MEM_rdes!=0 and MEM_rdes==EX_rs;
- else 01 when WB_RegWr=1, WB_rdes!=0 and WB_rdes==EX_rs;
- else 00.
ForwardB SHALL follow the same rule with EX_rt. The MEM match SHALL take priority over the WB match.
REQ-014 Register 0 SHALL never cause a stall or a forward.

Reset
REQ-015 While Reset_n=0 the block SHALL hold:
- state=RUN, int_en=1, synchronizer flops=0, EPC=0.
- All single-bit outputs 0; ForwardA=ForwardB=00.
REQ-016 Reset asserted mid-stall or mid-entry SHALL abort it immediately.
REQ-017 After reset release, the first acceptance SHALL need 2 fresh synchronizer samples.

Verification
REQ-018 Load-use: EX_MemRd=1, EX_rdes=8, ID_rs=8 -> PC_Hold, IFID_Hold and ID_Flush are 1 for 1 cycle, then the state is RUN with all holds 0.
REQ-019 Stall beats branch: LU and ID_BranchTaken=1 in the same cycle -> IF_Flush=0 and holds=1; with LU cleared next cycle, IF_Flush=1.
REQ-020 Interrupt: IRQ=1, ID_PCplus4=0x00400010 -> IRQ_Ack pulses 2 cycles later, EPC=0x0040000C, IF_Protect=1 the following cycle; a second IRQ is ignored until ID_Eret=1.
REQ-021 Blocked acceptance: IRQ held while ID_PCplus4=0 or ID_BranchTaken=1 -> no IRQ_Ack; acceptance occurs in the first cycle both are clear.
REQ-022 Forwarding: MEM_rdes=WB_rdes=EX_rs=5, both RegWr=1 -> ForwardA=10; with MEM_RegWr=0 -> 01; with EX_rs=0 -> 00.
REQ-023 Reset during IRQENTRY: Reset_n=0 -> IF_Protect=0, EPC=0 and int_en=1 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, interrupt entry
// with EPC capture, ERET re-enable, and EX operand forwarding select.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRt,
  input  logic        ID_BranchTaken,
  input  logic        ID_Eret,
  input  logic [31:0] ID_PCplus4,
  input  logic [4:0]  EX_rs,
  input  logic [4:0]  EX_rt,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_rdes,
  input  logic        MEM_RegWr,
  input  logic [4:0]  MEM_rdes,
  input  logic        WB_RegWr,
  input  logic [4:0]  WB_rdes,
  input  logic        IRQ,
  output logic        PC_Hold,
  output logic        IFID_Hold,
  output logic        IF_Flush,
  output logic        ID_Flush,
  output logic        IF_Protect,
  output logic        PCSrc_Irq,
  output logic        IRQ_Ack,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic [31:0] EPC
);

  typedef enum logic [1:0] {RUN, LDSTALL, IRQENTRY} state_t;

  state_t state;
  logic   int_en;
  logic   irq_meta;
  logic   irq_s;
  logic   lu;
  logic   accept;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       mem_wr,
                                         input logic [4:0] mem_rd,
                                         input logic       wb_wr,
                                         input logic [4:0] wb_rd);
    if (mem_wr && mem_rd != 5'd0 && mem_rd == src)
      return 2'b10;
    else if (wb_wr && wb_rd != 5'd0 && wb_rd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    lu = EX_MemRd && (EX_rdes != 5'd0) &&
         ((EX_rdes == ID_rs) || (ID_UsesRt && (EX_rdes == ID_rt)));
    accept = (state == RUN) && irq_s && int_en && !lu && !ID_BranchTaken &&
             !ID_Eret && (ID_PCplus4 != 32'd0);
  end

  // NOTE: every output gets a default before the case so no latch is inferred;
  // the whole set is also gated by Reset_n so it reads zero while reset is held.
  always_comb begin
    PC_Hold    = 1'b0;
    IFID_Hold  = 1'b0;
    IF_Flush   = 1'b0;
    ID_Flush   = 1'b0;
    IF_Protect = 1'b0;
    PCSrc_Irq  = 1'b0;
    IRQ_Ack    = 1'b0;
    ForwardA   = 2'b00;
    ForwardB   = 2'b00;
    if (Reset_n) begin
      ForwardA = fwd_sel(EX_rs, MEM_RegWr, MEM_rdes, WB_RegWr, WB_rdes);
      ForwardB = fwd_sel(EX_rt, MEM_RegWr, MEM_rdes, WB_RegWr, WB_rdes);
      case (state)
        RUN: begin
          if (lu) begin
            PC_Hold   = 1'b1;
            IFID_Hold = 1'b1;
            ID_Flush  = 1'b1;
          end else if (accept) begin
            IF_Flush  = 1'b1;
            ID_Flush  = 1'b1;
            PCSrc_Irq = 1'b1;
            IRQ_Ack   = 1'b1;
          end else begin
            IF_Flush  = ID_BranchTaken;
          end
        end
        LDSTALL:  IF_Flush   = ID_BranchTaken && !lu;
        IRQENTRY: IF_Protect = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the two-flop synchronizer a real chain.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      irq_meta <= 1'b0;
      irq_s    <= 1'b0;
    end else begin
      irq_meta <= IRQ;
      irq_s    <= irq_meta;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= RUN;
      int_en <= 1'b1;
      EPC    <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (lu) begin
            state <= LDSTALL;
          end else if (accept) begin
            state  <= IRQENTRY;
            int_en <= 1'b0;
            EPC    <= ID_PCplus4 - 32'd4;
          end else if (ID_Eret) begin
            int_en <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
